// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer state encoding, branch instruction ID range and PC width
package cpu_pkg;
  localparam int PC_W        = 32;
  localparam int BR_ID_FIRST = 15;
  localparam int BR_ID_LAST  = 20;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALTED} seq_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones; ports clk, reset, i_inc (count enable), o_cnt (value)
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (reset) r_cnt <= '0;
    else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/pc_branch_sequencer.sv
// pc_branch_sequencer: PC sequencer; imem req/ack fetch port, if_* valid/ready decode port, branch redirect with flush, halt, branch statistics
module pc_branch_sequencer import cpu_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd1,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_data,
  output logic             if_valid,
  output logic [31:0]      if_ir,
  output logic [PC_W-1:0]  if_pc,
  input  logic             id_ready,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             halt,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);
  seq_state_t      r_state;
  logic [PC_W-1:0] r_pc, r_tgt, r_ifpc;
  logic [31:0]     r_ir;
  logic            r_pend, r_halt, r_ifv, r_flush;
  logic            w_taken, w_halt, w_req, w_acc, w_stall;
  assign w_taken = br_valid & br_taken;
  assign w_halt  = r_halt | halt;
  // once a request is visible it stays up until acked; a new one needs a free if_* slot and no halt
  assign w_req   = (r_state == DRAIN) |
                   ((r_state == FETCH) & (r_pend | (!w_halt & (!r_ifv | id_ready))));
  assign w_acc   = w_req & imem_ack;
  assign w_stall = w_req & !imem_ack;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_tgt   <= RESET_PC;
      r_ir    <= '0;
      r_ifpc  <= '0;
      r_ifv   <= 1'b0;
      r_pend  <= 1'b0;
      r_halt  <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_flush <= w_taken;
      r_halt  <= w_halt;
      r_pend  <= w_stall;
      if (r_ifv && id_ready) r_ifv <= 1'b0;
      if (w_taken) begin
        r_ifv <= 1'b0;
        // an unacked request must finish at its original address; park the target until then
        if (w_stall) begin
          r_tgt   <= br_target;
          r_state <= DRAIN;
        end else begin
          r_pc    <= br_target;
          r_state <= (r_state == HALTED || (w_halt && r_state != IDLE)) ? HALTED : FETCH;
        end
      end else begin
        case (r_state)
          IDLE: r_state <= FETCH;
          FETCH: begin
            if (w_acc) begin
              r_ir   <= imem_data;
              r_ifpc <= r_pc;
              r_ifv  <= 1'b1;
              r_pc   <= r_pc + PC_STEP;
            end
            if (w_halt && !w_stall) r_state <= HALTED;
          end
          DRAIN: if (imem_ack) begin
            r_pc    <= r_tgt;
            r_state <= w_halt ? HALTED : FETCH;
          end
          default: ;
        endcase
      end
    end
  end
  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign if_valid  = r_ifv;
  assign if_ir     = r_ir;
  assign if_pc     = r_ifpc;
  assign flush     = r_flush;
  assign halted    = (r_state == HALTED);
  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk(clk), .reset(reset), .i_inc(br_valid), .o_cnt(br_count)
  );
  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk(clk), .reset(reset), .i_inc(w_taken), .o_cnt(taken_count)
  );
endmodule
